hbm_req_queue: RTL
==================

// Module: hbm_req_queue
// PURPOSE
//   Request front-end directly upstream of hbm_controller. Buffers read/write requests from
//   a valid/ready client in a DEPTH-entry FIFO and issues them to the controller one at a time.
//   Issues are single-cycle wr_en/rd_en pulses. Keeps one request outstanding, waits for
//   completion or timeout, then returns one response per request on a valid/ready channel.
// PARAMETERS
//   DEPTH      4    FIFO entries; power of 2, >=2
//   TIMEOUT    64   max cycles in WAIT before forced error completion; >=2
//   AW         32   address width
//   DW         512  data width
// PORTS
//   clk            in   1   clock
//   reset_n        in   1   asynchronous active-low reset
//   req_valid      in   1   client request valid
//   req_ready      out  1   queue can accept (= !full)
//   req_wr         in   1   1=write, 0=read
//   req_addr       in   AW  request address
//   req_data       in   DW  write data (ignored for reads)
//   rsp_valid      out  1   response valid, held until rsp_ready
//   rsp_ready      in   1   client accepts response
//   rsp_wr         out  1   response belongs to a write
//   rsp_error      out  1   controller error or timeout
//   rsp_data       out  DW  read data (0 for writes and errors)
//   ctrl_addr      out  AW  to hbm_controller addr
//   ctrl_data_in   out  DW  to hbm_controller data_in
//   ctrl_wr_en     out  1   to hbm_controller wr_en, 1-cycle pulse
//   ctrl_rd_en     out  1   to hbm_controller rd_en, 1-cycle pulse
//   ctrl_data_out  in   DW  from hbm_controller data_out
//   ctrl_ready     in   1   from hbm_controller hbm_ready
//   ctrl_error     in   1   from hbm_controller hbm_error
// BEHAVIOUR
//   Reset values: req_ready=1, rsp_valid=0, rsp_wr=0, rsp_error=0, rsp_data=0.
//     ctrl_wr_en=0, ctrl_rd_en=0, ctrl_addr=0, ctrl_data_in=0.
//     FIFO empty, pointers 0, timeout count 0, state IDLE.
//   Push: on posedge with req_valid && req_ready, store {wr,addr,data}. Pointers wrap mod DEPTH.
//     A full/empty ambiguity bit (extra pointer MSB) distinguishes the two cases.
//   Full: req_ready=0, no bypass. A same-cycle pop does not raise ready until the next cycle.
//   FSM IDLE: if FIFO non-empty && ctrl_ready && !rsp_valid -> ISSUE.
//     Pops the head into the issue register (ctrl_addr/ctrl_data_in).
//   FSM ISSUE: 1 cycle; ctrl_wr_en or ctrl_rd_en =1 per entry type; -> WAIT; timeout count cleared.
//   FSM WAIT: count++ each cycle; first cycle of WAIT ignores ctrl_ready.
//     Reason: the controller may still show ready from before the issue.
//     From the 2nd WAIT cycle on: ctrl_error=1 -> RESP with error=1.
//     Else ctrl_ready=1 -> RESP with error=0; capture ctrl_data_out into rsp_data for reads.
//     Error has priority over ready in the same cycle.
//     count reaches TIMEOUT-1 with neither -> RESP with error=1, rsp_data=0.
//   FSM RESP: rsp_valid=1, rsp_wr = type of issued entry; hold all rsp_* stable until rsp_ready.
//     rsp_valid && rsp_ready -> IDLE, rsp_valid=0 next cycle.
//   Latency: push at cycle T (idle queue, ctrl_ready=1) -> pop at T+1 -> ctrl_*_en at T+2.
//   Ordering: strictly FIFO; exactly one outstanding controller command; one response per request.
//   Simultaneous push and pop is allowed in any non-full state; occupancy is unchanged.
//   ctrl_error in IDLE/ISSUE/RESP is ignored.
//   Asynchronous reset mid-operation drops the in-flight command, queued entries and any pending response.
//     No pulse is emitted after reset release until a new push.
// TESTING
//   1 Write 0x10, data 0xDEADBEEF..., ctrl_ready=1 throughout.
//     -> one ctrl_wr_en pulse, addr 0x10, 2 cycles after push; rsp_wr=1, rsp_error=0.
//   2 Read 0x10; controller drops ready 3 cycles, then ready=1, data_out=0xDEADBEEF....
//     -> one ctrl_rd_en pulse; rsp_data=0xDEADBEEF..., rsp_error=0.
//   3 Push 5 writes (addr 0..4) with ctrl_ready=0, DEPTH=4.
//     -> req_ready low after 4; 5th accepted only after first pop.
//     Issue order 0,1,2,3,4.
//   4 Read issued, ctrl_ready=0 and ctrl_error=0 forever.
//     -> RESP after TIMEOUT=64 WAIT cycles; rsp_error=1, rsp_data=0.
//   5 ctrl_error=1 and ctrl_ready=1 in the same WAIT cycle -> rsp_error=1.
//     Also: rsp_ready held 0 for 10 cycles -> no further issue; rsp_* stable.
//   6 Reset asserted during WAIT with 3 entries queued.
//     -> all outputs at reset values; after release, no ctrl_*_en pulse until a new push.

Source files
------------

// File: rtl/hbm_req_queue_if.sv
// Client request/response channels of the HBM request queue.
// The client drives master; the queue sits on slave.
interface hbm_req_queue_if #(
   parameter int AW = 32,
   parameter int DW = 512
);
   logic          req_valid;
   logic          req_ready;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_wr;
   logic          rsp_error;
   logic [DW-1:0] rsp_data;

   modport master (
      output req_valid, req_wr, req_addr, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_wr, rsp_error, rsp_data
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_wr, rsp_error, rsp_data
   );
endinterface

// File: rtl/hbm_req_queue.sv
// Request FIFO in front of hbm_controller: one outstanding command,
// completion or timeout, then one response per request.
module hbm_req_queue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int AW      = 32,
   parameter int DW      = 512
) (
   input  logic           clk,
   input  logic           reset_n,
   hbm_req_queue_if.slave cli,
   output logic [AW-1:0]  ctrl_addr,
   output logic [DW-1:0]  ctrl_data_in,
   output logic           ctrl_wr_en,
   output logic           ctrl_rd_en,
   input  logic [DW-1:0]  ctrl_data_out,
   input  logic           ctrl_ready,
   input  logic           ctrl_error
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT);
   localparam int EW = 1 + AW + DW;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t nxt;

   logic [EW-1:0] mem [DEPTH];
   logic [PW:0]   wptr;
   logic [PW:0]   rptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   logic          iss_wr;
   logic [CW-1:0] cnt;
   logic          done;
   logic          done_err;

   logic          rsp_valid;
   logic          rsp_wr;
   logic          rsp_error;
   logic [DW-1:0] rsp_data;

   // Extra pointer MSB separates full from empty when the indices match.
   assign empty = (wptr == rptr);
   assign full  = (wptr[PW] != rptr[PW]) &&
                  (wptr[PW-1:0] == rptr[PW-1:0]);
   assign push  = cli.req_valid && !full;

   assign cli.req_ready = !full;
   assign cli.rsp_valid = rsp_valid;
   assign cli.rsp_wr    = rsp_wr;
   assign cli.rsp_error = rsp_error;
   assign cli.rsp_data  = rsp_data;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr[PW-1:0]] <= {cli.req_wr, cli.req_addr, cli.req_data};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt      = state;
      pop      = 1'b0;
      done     = 1'b0;
      done_err = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && ctrl_ready && !rsp_valid) begin
               nxt = ISSUE;
               pop = 1'b1;
            end
         end
         ISSUE: nxt = WAIT;
         WAIT: begin
            // A ready left over from before the issue is not a completion.
            if (cnt != '0 && ctrl_error) begin
               done     = 1'b1;
               done_err = 1'b1;
            end else if (cnt != '0 && ctrl_ready) begin
               done = 1'b1;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               done     = 1'b1;
               done_err = 1'b1;
            end
            if (done) begin
               nxt = RESP;
            end
         end
         RESP: begin
            if (cli.rsp_ready) begin
               nxt = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr         <= '0;
         rptr         <= '0;
         iss_wr       <= 1'b0;
         ctrl_addr    <= '0;
         ctrl_data_in <= '0;
         ctrl_wr_en   <= 1'b0;
         ctrl_rd_en   <= 1'b0;
         cnt          <= '0;
         rsp_valid    <= 1'b0;
         rsp_wr       <= 1'b0;
         rsp_error    <= 1'b0;
         rsp_data     <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
            {iss_wr, ctrl_addr, ctrl_data_in} <= mem[rptr[PW-1:0]];
         end
         ctrl_wr_en <= (state == ISSUE) && iss_wr;
         ctrl_rd_en <= (state == ISSUE) && !iss_wr;
         if (state == ISSUE) begin
            cnt <= '0;
         end else if (state == WAIT) begin
            cnt <= cnt + 1'b1;
         end
         if (done) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= iss_wr;
            rsp_error <= done_err;
            rsp_data  <= (done_err || iss_wr) ? '0 : ctrl_data_out;
         end else if (rsp_valid && cli.rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule
